// File: rtl/sram_dp_be.sv
// Simple-dual-port byte-enabled RAM with selectable read latency,
// write-first/read-old collision policy and a post-reset clear sweep.
module sram_dp_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int N_ENTRIES    = 1024,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    output logic                         init_busy_o,
    input  logic                         we_i,
    input  logic [$clog2(N_ENTRIES)-1:0] waddr_i,
    input  logic [DATA_WIDTH/8-1:0]      wbe_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic                         re_i,
    input  logic [$clog2(N_ENTRIES)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic                         rvalid_o
);

    localparam int AW = $clog2(N_ENTRIES);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state_reg, state_next;
    logic [AW-1:0]        clr_cnt_reg, clr_cnt_next;

    logic [DATA_WIDTH-1:0] mem [N_ENTRIES];

    logic [NB-1:0]         mem_be;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_fire;
    logic                  rd_coll;

    logic [DATA_WIDTH-1:0] ram_rd_reg;
    logic [NB-1:0]         byp_mask_reg;
    logic [DATA_WIDTH-1:0] byp_data_reg;
    logic                  rd_valid_reg;
    logic [DATA_WIDTH-1:0] s1_data;

    // State register and clear-sweep counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_INIT;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Sweep every entry once, then stay in RUN until the next reset
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (state_reg == ST_INIT) begin
            clr_cnt_next = clr_cnt_reg + AW'(1);
            if (clr_cnt_reg == AW'(N_ENTRIES - 1)) begin
                state_next = ST_RUN;
            end
        end
    end

    assign init_busy_o = (state_reg == ST_INIT);

    // Write port is shared between the clear sweep and user writes
    always_comb begin
        mem_be    = '0;
        mem_waddr = waddr_i;
        mem_wdata = wdata_i;
        if (state_reg == ST_INIT) begin
            mem_be    = '1;
            mem_waddr = clr_cnt_reg;
            mem_wdata = '0;
        end else if (we_i) begin
            mem_be    = wbe_i;
        end
    end

    assign rd_fire = (state_reg == ST_RUN) && re_i;
    // Only a write-first configuration needs to remember the colliding write
    assign rd_coll = rd_fire && we_i && (raddr_i == waddr_i) && (BYPASS != 0);

    // Byte-granular write into the array (no reset: the sweep clears it)
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_be[b]) begin
                mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Registered array read; loads only on a request so the word holds otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ram_rd_reg <= '0;
        end else if (rd_fire) begin
            ram_rd_reg <= mem[raddr_i];
        end
    end

    // Capture the bytes a same-cycle write would overlay on the old word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byp_mask_reg <= '0;
            byp_data_reg <= '0;
        end else if (rd_fire) begin
            byp_mask_reg <= rd_coll ? wbe_i : '0;
            byp_data_reg <= wdata_i;
        end
    end

    // First-stage valid, flushed asynchronously by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_fire;
        end
    end

    // Merge bypassed write bytes over the array word
    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
        assign s1_data[8*gi +: 8] = byp_mask_reg[gi] ? byp_data_reg[8*gi +: 8]
                                                     : ram_rd_reg[8*gi +: 8];
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] out_data_reg;
        logic                  out_valid_reg;

        // Extra output register stage; data held while no new word arrives
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                out_data_reg  <= '0;
                out_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= rd_valid_reg;
                if (rd_valid_reg) begin
                    out_data_reg <= s1_data;
                end
            end
        end

        assign rdata_o  = out_data_reg;
        assign rvalid_o = out_valid_reg;
    end else begin : g_lat1
        assign rdata_o  = s1_data;
        assign rvalid_o = rd_valid_reg;
    end

endmodule

// File: tb/tb_sram_dp_be.sv
// Self-checking bench: four instances (latency 1/2 x write-first/read-old)
// driven by the same stimulus and checked every cycle against a
// cycle-stamped behavioural model, plus literal checks from the test plan.
module tb_sram_dp_be;

    localparam int N  = 16;
    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        we = 1'b0, re = 1'b0;
    logic [3:0]  waddr = '0, raddr = '0, wbe = '0;
    logic [31:0] wdata = '0;

    logic [31:0] rdata  [NI];
    logic        rvalid [NI];
    logic        busy   [NI];

    always #5 clk = ~clk;

    // Instance k: latency = k%2 + 1, write-first when k < 2
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        sram_dp_be #(
            .DATA_WIDTH  (32),
            .N_ENTRIES   (N),
            .READ_LATENCY(gi % 2 + 1),
            .BYPASS      ((gi < 2) ? 1 : 0)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_ni),
            .init_busy_o(busy[gi]),
            .we_i       (we),
            .waddr_i    (waddr),
            .wbe_i      (wbe),
            .wdata_i    (wdata),
            .re_i       (re),
            .raddr_i    (raddr),
            .rdata_o    (rdata[gi]),
            .rvalid_o   (rvalid[gi])
        );
    end

    typedef struct {
        int          due;
        logic [31:0] d;
    } rd_t;

    rd_t         pq [NI][$];
    logic [31:0] m_mem [N];
    int          init_left = N;
    int          cyc = 0;
    logic [31:0] last_d [NI];
    logic [31:0] cap [NI];
    int          vcnt [NI];
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic int lat_of(int k);
        return k % 2 + 1;
    endfunction

    function automatic bit byp_of(int k);
        return k < 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        init_left = N;
        for (int k = 0; k < NI; k++) begin
            pq[k].delete();
            last_d[k] = '0;
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            last_d[k] = '0;
            cap[k]    = '0;
            vcnt[k]   = 0;
        end
    end

    always @(negedge rst_ni) model_reset();

    // Model: at each edge apply the sweep or the request; a read sampled at
    // edge c is due after edge c + latency - 1.
    always @(posedge clk) begin
        logic [31:0] old_w;
        logic [31:0] mrg_w;
        rd_t         e;
        cyc++;
        if (!rst_ni) begin
            model_reset();
        end else if (init_left > 0) begin
            m_mem[N - init_left] = '0;
            init_left--;
        end else begin
            if (re) begin
                old_w = m_mem[raddr];
                mrg_w = old_w;
                if (we && waddr == raddr)
                    for (int b = 0; b < 4; b++)
                        if (wbe[b]) mrg_w[8*b +: 8] = wdata[8*b +: 8];
                for (int k = 0; k < NI; k++) begin
                    e.due = cyc + lat_of(k) - 1;
                    e.d   = byp_of(k) ? mrg_w : old_w;
                    pq[k].push_back(e);
                end
            end
            if (we)
                for (int b = 0; b < 4; b++)
                    if (wbe[b]) m_mem[waddr][8*b +: 8] = wdata[8*b +: 8];
        end
    end

    // Compare all outputs every cycle, between edges
    always @(negedge clk) begin
        bit ev;
        for (int k = 0; k < NI; k++) begin
            ev = 1'b0;
            if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
                ev = 1'b1;
                last_d[k] = pq[k][0].d;
                void'(pq[k].pop_front());
            end
            check($sformatf("rvalid[%0d]", k), {31'b0, rvalid[k]}, {31'b0, ev});
            check($sformatf("rdata[%0d]", k), rdata[k], last_d[k]);
            check($sformatf("busy[%0d]", k), {31'b0, busy[k]}, (init_left > 0) ? 32'd1 : 32'd0);
            if (rvalid[k]) begin
                cap[k] = rdata[k];
                vcnt[k]++;
            end
        end
    end

    task automatic drive(input logic w, input logic [3:0] wa, input logic [3:0] be,
                         input logic [31:0] wd, input logic r, input logic [3:0] ra);
        @(negedge clk);
        #1;
        we = w; waddr = wa; wbe = be; wdata = wd; re = r; raddr = ra;
        $display("cyc %0d: we=%0b wa=%0d be=%h wd=%08h re=%0b ra=%0d", cyc, w, wa, be, wd, r, ra);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
    endtask

    task automatic set_cap();
        for (int k = 0; k < NI; k++) cap[k] = 32'h5A5A5A5A;
    endtask

    task automatic check_cap(input string name, input logic [31:0] e_byp, input logic [31:0] e_old);
        for (int k = 0; k < NI; k++)
            check($sformatf("%s[%0d]", name, k), cap[k], byp_of(k) ? e_byp : e_old);
    endtask

    // Called right after rst_ni rises mid-cycle: the release cycle counts as one
    task automatic count_init(input string name);
        int c;
        #1;
        c = busy[0] ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy[0]) c++;
        end
        check(name, c, 32'd16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v0 [NI];
        re = 1'b1; raddr = 4'd3;
        repeat (3) @(negedge clk);
        #1 rst_ni = 1'b1;
        // Reads of addr 3 are requested throughout the sweep and must be ignored
        count_init("init_len");
        idle(2);

        set_cap();
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd3);
        idle(3);
        check_cap("clear_rd3", 32'h00000000, 32'h00000000);

        // Byte enables
        drive(1'b1, 4'd5, 4'b1111, 32'hAABBCCDD, 1'b0, 4'd0);
        drive(1'b1, 4'd5, 4'b0101, 32'h11223344, 1'b0, 4'd0);
        set_cap();
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd5);
        idle(3);
        check_cap("byte_en", 32'hAA22CC44, 32'hAA22CC44);
        check("model_byte_en", m_mem[5], 32'hAA22CC44);

        // Back-to-back reads; per-cycle timing is checked by the model
        for (int a = 0; a < 4; a++)
            drive(1'b1, 4'(a), 4'b1111, 32'h10 + 32'(a), 1'b0, 4'd0);
        for (int k = 0; k < NI; k++) v0[k] = vcnt[k];
        set_cap();
        for (int a = 0; a < 4; a++)
            drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(a));
        idle(4);
        check_cap("burst_last", 32'h13, 32'h13);
        for (int k = 0; k < NI; k++)
            check($sformatf("burst_pulses[%0d]", k), vcnt[k] - v0[k], 32'd4);

        // Collision
        drive(1'b1, 4'd7, 4'b1111, 32'h12345678, 1'b0, 4'd0);
        set_cap();
        drive(1'b1, 4'd7, 4'b0011, 32'hFFFFFFFF, 1'b1, 4'd7);
        idle(3);
        check_cap("collide", 32'h1234FFFF, 32'h12345678);
        set_cap();
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd7);
        idle(3);
        check_cap("after_collide", 32'h1234FFFF, 32'h1234FFFF);

        // Write then read next cycle
        drive(1'b1, 4'd2, 4'b1111, 32'hCAFEF00D, 1'b0, 4'd0);
        set_cap();
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd2);
        idle(3);
        check_cap("wr_then_rd", 32'hCAFEF00D, 32'hCAFEF00D);

        // Reset with reads in flight
        drive(1'b1, 4'd9, 4'b1111, 32'hDEADBEEF, 1'b0, 4'd0);
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd9);
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd9);
        @(negedge clk);
        for (int k = 0; k < NI; k++)
            check($sformatf("pre_rst_valid[%0d]", k), {31'b0, rvalid[k]}, 32'd1);
        #1;
        rst_ni = 1'b0; re = 1'b0; we = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("async_rvalid[%0d]", k), {31'b0, rvalid[k]}, 32'd0);
            check($sformatf("async_rdata[%0d]", k), rdata[k], 32'd0);
        end
        @(negedge clk);
        #1 rst_ni = 1'b1;
        count_init("init_len_rerun");
        set_cap();
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd9);
        idle(3);
        check_cap("rd9_cleared", 32'd0, 32'd0);

        // Randomised traffic, with a reset and a second reset inside the sweep
        for (int i = 0; i < 2500; i++) begin
            if (i == 1000 || i == 1008) begin
                @(negedge clk);
                #1 rst_ni = 1'b0;
                @(negedge clk);
                #1 rst_ni = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 32'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
- Parametrised simple-dual-port BRAM for cache tag/data storage.
- Successor of the single-port cache SRAM: one write port and one read port operate in the same cycle.
- Adds per-byte write enables, selectable read latency (1 or 2), deterministic read/write collision handling, read-valid tracking, and a post-reset hardware clear sweep.
- Instantiated by the I/D-cache controllers; the clear sweep replaces software invalidation loops.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8 and at least 8.
- N_ENTRIES, 1024, number of words; power of two, at least 2.
- READ_LATENCY, 1, cycles from read request to data; only 1 or 2 are legal (2 adds an output register).
- BYPASS, 1, same-cycle same-address collision policy: 1 = write-first (merged data), 0 = read-old.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- init_busy_o  out  1  high while the clear sweep runs; all requests are ignored while high.
- we_i  in  1  write request.
- waddr_i  in  $clog2(N_ENTRIES)  write address.
- wbe_i  in  DATA_WIDTH/8  byte enables; bit b covers wdata_i[8b+7:8b].
- wdata_i  in  DATA_WIDTH  write data.
- re_i  in  1  read request.
- raddr_i  in  $clog2(N_ENTRIES)  read address.
- rdata_o  out  DATA_WIDTH  read data.
- rvalid_o  out  1  rdata_o is valid this cycle.

Behaviour:
- Reset (asynchronous assert, rst_ni=0):
  - FSM goes to INIT, clear counter = 0.
  - init_busy_o = 1, rvalid_o = 0, rdata_o = 0.
  - All read pipeline valid bits are flushed.
- FSM states are INIT and RUN.
- INIT:
  - Each cycle after rst_ni rises, writes all-zero to entry[counter], then increments the counter.
  - After entry N_ENTRIES-1 is written, moves to RUN.
  - init_busy_o falls in the cycle after the last clear write, so it is high for exactly N_ENTRIES cycles after reset release.
  - we_i and re_i are ignored in INIT: no write happens and no rvalid_o is generated.
- RUN is terminal until the next reset.
- Reset mid-operation (in either state): immediate return to INIT, in-flight reads are discarded, and the full clear sweep restarts from entry 0.
- Write (RUN, we_i=1):
  - For each b with wbe_i[b]=1, byte b of entry[waddr_i] takes the matching byte of wdata_i at the clock edge.
  - Disabled bytes keep their value; wbe_i = 0 is a no-op.
- Read (RUN, re_i=1 in cycle T):
  - The array is sampled at the edge ending cycle T.
  - READ_LATENCY=1: rdata_o and rvalid_o=1 appear in cycle T+1.
  - READ_LATENCY=2: rdata_o and rvalid_o=1 appear in cycle T+2.
  - rvalid_o pulses for exactly one cycle per request.
  - Full throughput: one read per cycle, back-to-back, with no bubbles.
  - rdata_o holds its last value while rvalid_o=0.
- Collision (re_i and we_i both set, raddr_i == waddr_i, same cycle):
  - BYPASS=1: the returned word has new bytes where wbe_i is set and old bytes elsewhere.
  - BYPASS=0: the returned word is entirely the old value.
  - In both cases the array is updated as for a normal write.
- Write in cycle T followed by a read of the same address in cycle T+1 always returns the new data, for either latency setting.
- A write issued after a read has been sampled never alters that read's in-flight data.
- Address width is $clog2(N_ENTRIES) bits, so there is no out-of-range address.

Test Plan:
- Clear sweep (N_ENTRIES=16): release rst_ni; drive re_i=1 to addr 3 during INIT -> init_busy_o stays 1 for exactly 16 cycles with rvalid_o=0 throughout; a read of addr 3 after init returns 0x00000000.
- Byte enables: write 0xAABBCCDD with wbe=4'b1111 to addr 5, then 0x11223344 with wbe=4'b0101 -> a later read of addr 5 returns 0xAA22CC44.
- Latency and throughput (READ_LATENCY=2): write entries 0..3 with 0x10..0x13, then read 0,1,2,3 on consecutive cycles T..T+3 -> rvalid_o is high in T+2..T+5 with data 0x10,0x11,0x12,0x13; rerun with READ_LATENCY=1 -> data appears in T+1..T+4.
- Collision:
  - Setup: addr 7 holds 0x12345678; issue write 0xFFFFFFFF with wbe=4'b0011 plus a read of addr 7 in the same cycle.
  - BYPASS=1 -> read returns 0x1234FFFF.
  - BYPASS=0 -> read returns 0x12345678.
  - Either setting -> the next read of addr 7 returns 0x1234FFFF.
- Reset mid-operation: with reads in flight and addr 9 = 0xDEADBEEF, pulse rst_ni low for 1 cycle -> rvalid_o drops to 0 asynchronously and no stale pulse follows; init_busy_o is high for 16 cycles; addr 9 then reads 0.
- Write-then-read: write 0xCAFEF00D to addr 2 in cycle T, read addr 2 in T+1 -> returns 0xCAFEF00D for both latency settings.
